// File: rtl/lane_gate_scheduler.sv
// Purpose: arbitrates the shared barrier lane between entry and exit cars and sequences the barrier.
// Latency: every output is registered; a grant appears one cycle after the IDLE cycle that sees a request.
// Backpressure: none; requests are levels sampled only in IDLE, so a waiting car simply holds its request.
module lane_gate_scheduler #(
  parameter int TRAVEL_CYCLES = 4,
  parameter int PASS_TIMEOUT  = 16,
  parameter int TMR_W         = 5
) (
  input  logic clk,
  input  logic Start,
  input  logic Req_In,
  input  logic Req_Out,
  input  logic Pass,
  input  logic Full,
  input  logic Closed,
  input  logic Override,
  output logic Gate_Up,
  output logic Grant_In,
  output logic Grant_Out,
  output logic Car_In,
  output logic Car_Out,
  output logic Timeout_Err,
  output logic Busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAISE     = 3'd1,
    WAIT_PASS = 3'd2,
    LOWER     = 3'd3,
    OVR       = 3'd4
  } state_t;

  localparam logic [TMR_W-1:0] TRAVEL_LAST = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0] PASS_LAST   = TMR_W'(PASS_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX     = '1;

  state_t           state_q, state_n;
  logic [TMR_W-1:0] timer_q, timer_n, timer_inc;
  logic             seen_q, seen_n;          // Pass has been high during this WAIT_PASS
  logic             last_out_q, last_out_n;  // 1 when the exit direction was served last
  logic             elig_in, elig_out;
  logic             grant_in_n, grant_out_n;
  logic             car_in_n, car_out_n, tmo_n;
  logic             gate_n, busy_n;

  // Saturating increment so a long OVR stay can never wrap the timer.
  assign timer_inc = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);

  // Exits are never blocked; entries respect the occupancy status.
  assign elig_in  = Req_In & ~Full & ~Closed;
  assign elig_out = Req_Out;

  // Next-state, timer and next registered-output computation.
  always_comb begin
    state_n     = state_q;
    timer_n     = timer_inc;
    seen_n      = 1'b0;
    last_out_n  = last_out_q;
    grant_in_n  = Grant_In;
    grant_out_n = Grant_Out;
    car_in_n    = 1'b0;
    car_out_n   = 1'b0;
    tmo_n       = 1'b0;

    if (Override) begin
      // Manual override discards any transaction in flight without reporting it.
      state_n     = OVR;
      grant_in_n  = 1'b0;
      grant_out_n = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_n     = '0;
          grant_in_n  = 1'b0;
          grant_out_n = 1'b0;
          // On a tie the entry wins only if the exit was served last.
          if (elig_in && (!elig_out || last_out_q)) begin
            state_n    = RAISE;
            grant_in_n = 1'b1;
            last_out_n = 1'b0;
          end else if (elig_out) begin
            state_n     = RAISE;
            grant_out_n = 1'b1;
            last_out_n  = 1'b1;
          end
        end

        RAISE: begin
          if (timer_q == TRAVEL_LAST) begin
            state_n = WAIT_PASS;
          end
        end

        WAIT_PASS: begin
          seen_n = seen_q | Pass;
          // Once the car has been seen the timeout no longer applies, so freeze the timer.
          if (seen_q) begin
            timer_n = timer_q;
          end
          if (seen_q && !Pass) begin
            state_n   = LOWER;
            car_in_n  = Grant_In;
            car_out_n = Grant_Out;
          end else if (!seen_q && !Pass && (timer_q == PASS_LAST)) begin
            // A car arriving on the very last cycle counts as seen, not as a timeout.
            state_n = LOWER;
            tmo_n   = 1'b1;
          end
        end

        LOWER: begin
          if (timer_q == TRAVEL_LAST) begin
            state_n     = IDLE;
            grant_in_n  = 1'b0;
            grant_out_n = 1'b0;
          end
        end

        OVR: begin
          // Override has dropped: bring the barrier down with no grant.
          state_n     = LOWER;
          grant_in_n  = 1'b0;
          grant_out_n = 1'b0;
        end

        default: begin
          state_n     = IDLE;
          grant_in_n  = 1'b0;
          grant_out_n = 1'b0;
        end
      endcase
    end

    // Timer and seen flag restart on every state entry.
    if (state_n != state_q) begin
      timer_n = '0;
      seen_n  = 1'b0;
    end
  end

  // Outputs are registered images of the state being entered.
  assign gate_n = (state_n == RAISE) || (state_n == WAIT_PASS) || (state_n == OVR);
  assign busy_n = (state_n != IDLE);

  // State, timer, arbitration history and registered outputs.
  always_ff @(posedge clk or posedge Start) begin
    if (Start) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      seen_q      <= 1'b0;
      last_out_q  <= 1'b1;
      Gate_Up     <= 1'b0;
      Grant_In    <= 1'b0;
      Grant_Out   <= 1'b0;
      Car_In      <= 1'b0;
      Car_Out     <= 1'b0;
      Timeout_Err <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      timer_q     <= timer_n;
      seen_q      <= seen_n;
      last_out_q  <= last_out_n;
      Gate_Up     <= gate_n;
      Grant_In    <= grant_in_n;
      Grant_Out   <= grant_out_n;
      Car_In      <= car_in_n;
      Car_Out     <= car_out_n;
      Timeout_Err <= tmo_n;
      Busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_lane_gate_scheduler.sv
// Purpose: self-checking bench for lane_gate_scheduler (directed table, corner sequences, random transactions).
// Latency: outputs checked 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: not applicable; the bench walks each transaction cycle by cycle.
module tb_lane_gate_scheduler;

  localparam int T  = 4;
  localparam int PT = 16;
  localparam int W  = 5;

  localparam int G_NONE = 0;
  localparam int G_IN   = 1;
  localparam int G_OUT  = 2;

  localparam int P_NONE = 0;
  localparam int P_CIN  = 1;
  localparam int P_COUT = 2;
  localparam int P_TMO  = 3;

  logic clk = 1'b0;
  logic Start = 1'b1;
  logic Req_In = 1'b0;
  logic Req_Out = 1'b0;
  logic Pass = 1'b0;
  logic Full = 1'b0;
  logic Closed = 1'b0;
  logic Override = 1'b0;
  logic Gate_Up, Grant_In, Grant_Out, Car_In, Car_Out, Timeout_Err, Busy;

  int tests = 0;
  int fails = 0;

  // Reference arbitration history: 1 when the exit direction was granted last.
  logic m_last_out = 1'b1;

  lane_gate_scheduler #(
    .TRAVEL_CYCLES(T),
    .PASS_TIMEOUT (PT),
    .TMR_W        (W)
  ) dut (
    .clk        (clk),
    .Start      (Start),
    .Req_In     (Req_In),
    .Req_Out    (Req_Out),
    .Pass       (Pass),
    .Full       (Full),
    .Closed     (Closed),
    .Override   (Override),
    .Gate_Up    (Gate_Up),
    .Grant_In   (Grant_In),
    .Grant_Out  (Grant_Out),
    .Car_In     (Car_In),
    .Car_Out    (Car_Out),
    .Timeout_Err(Timeout_Err),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ri;
    logic ro;
    logic fu;
    logic cl;
    int   d;   // Pass rises this many WAIT_PASS cycles after entry; -1 = never
    int   h;   // Pass high length; for no-grant rows, number of idle cycles watched
    int   g;   // expected grant
    int   p;   // expected pulse
  } vec_t;

  vec_t tbl[11];

  function automatic logic [6:0] outs();
    return {Gate_Up, Grant_In, Grant_Out, Car_In, Car_Out, Timeout_Err, Busy};
  endfunction

  function automatic logic [6:0] mk(input logic gate, input int g, input int p, input logic busy);
    return {gate, g == G_IN, g == G_OUT, p == P_CIN, p == P_COUT, p == P_TMO, busy};
  endfunction

  // Round-robin arbitration from the eligibility rules.
  function automatic int pick(input logic ri, input logic ro, input logic fu, input logic cl);
    logic ei;
    logic eo;
    ei = ri & ~fu & ~cl;
    eo = ro;
    if (ei && eo) return m_last_out ? G_IN : G_OUT;
    if (ei) return G_IN;
    if (eo) return G_OUT;
    return G_NONE;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [6:0] exp);
    logic [6:0] act;
    act = outs();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b (Gate,GrIn,GrOut,CarIn,CarOut,Tmo,Busy)", nm, act, exp);
    end
  endtask

  // Requests and status are irrelevant once a transaction is granted.
  task automatic noise();
    Req_In  = 1'($urandom_range(0, 1));
    Req_Out = 1'($urandom_range(0, 1));
    Full    = 1'($urandom_range(0, 1));
    Closed  = 1'($urandom_range(0, 1));
  endtask

  // Walks one transaction from IDLE and checks every cycle of its timeline.
  task automatic run_txn(input logic ri, input logic ro, input logic fu, input logic cl,
                         input int d, input int h, input int g, input int p, input string nm);
    int nwait;
    Req_In  = ri;
    Req_Out = ro;
    Full    = fu;
    Closed  = cl;
    Pass    = 1'b0;
    step();
    if (g == G_NONE) begin
      for (int i = 0; i < h; i++) begin
        chk($sformatf("%s idle%0d", nm, i), 7'b0);
        step();
      end
      Req_In  = 1'b0;
      Req_Out = 1'b0;
      Full    = 1'b0;
      Closed  = 1'b0;
    end else begin
      m_last_out = (g == G_OUT);
      for (int i = 0; i < T; i++) begin
        chk($sformatf("%s raise%0d", nm, i), mk(1'b1, g, P_NONE, 1'b1));
        noise();
        step();
      end
      nwait = (d >= 0) ? d + h + 1 : PT;
      for (int k = 0; k < nwait; k++) begin
        chk($sformatf("%s wait%0d", nm, k), mk(1'b1, g, P_NONE, 1'b1));
        noise();
        Pass = (d >= 0) && (k >= d) && (k < d + h);
        step();
      end
      Pass = 1'b0;
      for (int j = 0; j < T; j++) begin
        chk($sformatf("%s lower%0d", nm, j), mk(1'b0, g, (j == 0) ? p : P_NONE, 1'b1));
        noise();
        step();
      end
      chk($sformatf("%s back_idle", nm), 7'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int p;
    int d;
    int h;
    logic ri, ro, fu, cl;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 2, G_IN, P_CIN};      // first tie goes to entry
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1, G_OUT, P_COUT};    // then exit
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 2, G_IN, P_CIN};      // then entry again
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 3, G_IN, P_CIN};      // single entry
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 2, G_OUT, P_COUT};    // Full blocks entry only
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, -1, 50, G_NONE, P_NONE}; // Closed: no grant for 50 cycles
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, -1, 5, G_NONE, P_NONE};  // Full: no entry grant
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, -1, 0, G_OUT, P_TMO};    // exit times out
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 40, G_OUT, P_COUT};  // long pass, no timeout
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5, 1, G_OUT, P_COUT};    // Closed never blocks exit
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, PT - 2, 1, G_IN, P_CIN}; // latest pass before timeout

    // Reset state, both while held and after release.
    Start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_held", 7'b0);
    Start = 1'b0;
    m_last_out = 1'b1;
    step();
    chk("idle_after_reset", 7'b0);

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i].ri, tbl[i].ro, tbl[i].fu, tbl[i].cl, tbl[i].d, tbl[i].h,
              tbl[i].g, tbl[i].p, $sformatf("tbl%0d", i));
    end

    // Override during WAIT_PASS discards the entry transaction.
    Req_In  = 1'b1;
    Req_Out = 1'b0;
    Full    = 1'b0;
    Closed  = 1'b0;
    Pass    = 1'b0;
    step();
    m_last_out = 1'b0;
    for (int i = 0; i < T; i++) begin
      chk($sformatf("ovr_raise%0d", i), mk(1'b1, G_IN, P_NONE, 1'b1));
      step();
    end
    Req_In = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ovr_wait%0d", i), mk(1'b1, G_IN, P_NONE, 1'b1));
      step();
    end
    Override = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ovr_hold%0d", i), mk(1'b1, G_NONE, P_NONE, 1'b1));
      Pass = (i == 0);
      step();
    end
    Override = 1'b0;
    Pass     = 1'b0;
    step();
    for (int j = 0; j < T; j++) begin
      chk($sformatf("ovr_lower%0d", j), mk(1'b0, G_NONE, P_NONE, 1'b1));
      step();
    end
    chk("ovr_back_idle", 7'b0);

    // Asynchronous Start during RAISE.
    Req_In  = 1'b1;
    Req_Out = 1'b1;
    g = pick(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("rst_raise0", mk(1'b1, g, P_NONE, 1'b1));
    step();
    chk("rst_raise1", mk(1'b1, g, P_NONE, 1'b1));
    #2 Start = 1'b1;
    #1 chk("async_reset", 7'b0);
    #1 Start = 1'b0;
    m_last_out = 1'b1;
    Req_In  = 1'b0;
    Req_Out = 1'b0;
    step();
    chk("post_reset_idle", 7'b0);
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 1, 2, G_IN, P_CIN, "post_reset_tie");

    // Random transactions against the reference model.
    for (int n = 0; n < 40; n++) begin
      ri = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      fu = 1'($urandom_range(0, 1));
      cl = 1'($urandom_range(0, 1));
      g  = pick(ri, ro, fu, cl);
      if ($urandom_range(0, 3) == 0) d = -1;
      else d = int'($urandom_range(0, PT - 2));
      h = int'($urandom_range(1, 6));
      if (g == G_NONE) begin
        p = P_NONE;
        h = 2;
      end else if (d < 0) begin
        p = P_TMO;
      end else begin
        p = (g == G_IN) ? P_CIN : P_COUT;
      end
      run_txn(ri, ro, fu, cl, d, h, g, p, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lane_gate_scheduler.md
Name: lane_gate_scheduler

Overview:
- Sequences the single shared barrier lane of the garage between the entry requester (Req_In) and the exit requester (Req_Out).
- Grants the lane, raises the barrier, waits for the car to clear the pass sensor, lowers the barrier, then reports one Car_In or Car_Out pulse to the occupancy FSM.
- Honours the occupancy FSM's Full and Closed status and its Override mode, and flags stuck transactions with a timeout.

Parameters:
- TRAVEL_CYCLES, 4: cycles the barrier is held in RAISE and in LOWER (travel time); minimum 1.
- PASS_TIMEOUT, 16: maximum cycles in WAIT_PASS without the pass sensor asserting; minimum 2.
- TMR_W, 5: width of the shared travel/timeout timer; must hold max(TRAVEL_CYCLES, PASS_TIMEOUT).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- Start  input  1  asynchronous, active-high reset.
- Req_In  input  1  entry car present at the lane (level).
- Req_Out  input  1  exit car present at the lane (level).
- Pass  input  1  car-in-barrier sensor (level); high while a car occupies the barrier.
- Full  input  1  garage full, from the occupancy FSM.
- Closed  input  1  garage closed, from the occupancy FSM.
- Override  input  1  manual override: barrier forced up.
- Gate_Up  output  1  barrier command; 1 = raise/hold up.
- Grant_In  output  1  lane granted to the entry direction for the whole transaction.
- Grant_Out  output  1  lane granted to the exit direction for the whole transaction.
- Car_In  output  1  one-cycle pulse per completed entry.
- Car_Out  output  1  one-cycle pulse per completed exit.
- Timeout_Err  output  1  one-cycle pulse when a transaction times out.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered. While Start is high: state=IDLE, timer=0, last_served=OUT (so entry wins the first tie), and every output is 0.
- States: IDLE, RAISE, WAIT_PASS, LOWER, OVR. Busy is high in every state except IDLE.
- Eligibility: entry is eligible when Req_In & !Full & !Closed. Exit is eligible when Req_Out; exits are never blocked by Full or Closed.
- IDLE:
  - If exactly one direction is eligible, grant it.
  - If both are eligible, grant the direction opposite last_served (round robin).
  - On a grant, in the next cycle: state=RAISE, Grant_x=1, Gate_Up=1, timer=0, and last_served is updated.
- RAISE:
  - Lasts exactly TRAVEL_CYCLES cycles with Gate_Up=1, then moves to WAIT_PASS with timer=0.
- WAIT_PASS:
  - Gate_Up=1. The timer counts while Pass has not yet been seen high.
  - A seen-high flag sets on the first cycle Pass=1.
  - Completion: on a cycle where the flag is set and Pass=0 (the car has cleared):
    - pulse Car_In or Car_Out for that cycle, matching the grant;
    - enter LOWER with timer=0.
  - Timeout: if the timer reaches PASS_TIMEOUT-1 with the flag clear:
    - pulse Timeout_Err; no Car pulse;
    - enter LOWER.
  - Once the flag is set, no timeout applies; the block waits indefinitely for Pass to fall.
- LOWER:
  - Gate_Up=0. After TRAVEL_CYCLES cycles, clear both grants and return to IDLE.
  - The grant is held through LOWER.
- Transactions are non-abortable:
  - Req_x dropping, Full rising, or Closed rising after the grant does not change the sequence or the reported pulse.
  - A new grant is evaluated only in IDLE, so at least one IDLE cycle separates transactions.
- Override:
  - Override=1 in any state moves to OVR next cycle: Gate_Up=1, both grants=0, no Car or Timeout pulses.
  - If a transaction was in flight it is discarded and no pulse is emitted for it.
  - Override falling moves from OVR to LOWER with no grant, then to IDLE.
- Timer: TMR_W-bit, reset on every state entry, saturates (never wraps).
- Pulses: at most one of Car_In, Car_Out, Timeout_Err is high in any cycle.
- Asynchronous Start mid-transaction returns to the reset state immediately; no pulse is emitted.

Test Plan:
- Single entry: Req_In=1, Full=0. Expect Grant_In and Gate_Up high 1 cycle later. Assert Pass for 3 cycles after RAISE. Expect Car_In high 1 cycle at Pass fall, Gate_Up low for 4 cycles, then Busy=0. Car_Out never pulses.
- Tie/round-robin: Req_In=Req_Out=1 held across 3 transactions. Expect grants in the order IN, OUT, IN, with one Car pulse each.
- Full/Closed: Full=1 with Req_In=Req_Out=1 → only Grant_Out. Closed=1 with Req_In only → no grant, Busy stays 0 for 50 cycles.
- Timeout: grant an exit and keep Pass=0. Expect Timeout_Err pulse exactly 16 cycles after WAIT_PASS entry, no Car_Out, then LOWER → IDLE. Repeat with Pass high from cycle 10 and held for 40 cycles → no timeout; Car_Out pulses at Pass fall.
- Override mid-transaction: assert Override during WAIT_PASS. Expect OVR next cycle with Gate_Up=1, grants=0. Release Override → expect 4 LOWER cycles and no Car or Timeout pulse.
- Reset mid-RAISE: pulse Start asynchronously. Expect all outputs 0 immediately. A subsequent tie resolves to IN.
